// File: rtl/mult_div.sv
// Iterative signed multiply / divide unit.
// Multiply: radix-2 Booth, one step per cycle, DATA_W steps, {hi,lo} = a*b.
// Divide: restoring division on magnitudes, DATA_W steps, then sign fix-up;
// quotient truncates toward zero, remainder takes the dividend's sign.
// Divide by zero finishes at once, flags div_zero and leaves hi/lo alone.
module mult_div #(
  parameter int DATA_W = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     op,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] hi,
  output logic signed [DATA_W-1:0] lo,
  output logic                     busy,
  output logic                     done,
  output logic                     div_zero
);

  typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

  localparam logic [5:0] LAST_STEP = 6'(DATA_W - 1);

  state_t            state, state_nxt;
  logic [5:0]        cnt;
  logic [DATA_W:0]   acc;    // Booth partial product (A) or division remainder
  logic [DATA_W-1:0] qreg;   // Booth multiplier (Q) or quotient being built
  logic [DATA_W-1:0] mreg;   // multiplicand or divisor magnitude
  logic              qm1;    // Booth q(-1) bit
  logic              neg_q;  // quotient must be negated
  logic              neg_r;  // remainder must be negated

  logic cap, step, last, dz;
  logic [2*DATA_W+1:0] booth_nxt;
  logic [2*DATA_W:0]   div_nxt;
  logic [DATA_W-1:0]   res_hi, res_lo;

  // Magnitude of a two's complement value; the most negative value maps to 2^(W-1).
  function automatic logic [DATA_W-1:0] abs_mag(input logic [DATA_W-1:0] x);
    return x[DATA_W-1] ? (~x + 1'b1) : x;
  endfunction

  // Conditional two's complement negation used for the divide sign fix-up.
  function automatic logic [DATA_W-1:0] neg_if(input logic n, input logic [DATA_W-1:0] x);
    return n ? (~x + 1'b1) : x;
  endfunction

  // One Booth step: add/subtract M by {Q0,q-1}, then arithmetic shift of {A,Q,q-1}.
  // A is one bit wider than the operands so that subtracting the most negative
  // multiplicand cannot overflow. Result layout: {A, Q, q-1}.
  function automatic logic [2*DATA_W+1:0] booth_step(input logic [DATA_W:0]   a_in,
                                                     input logic [DATA_W-1:0] q_in,
                                                     input logic              q_m1,
                                                     input logic [DATA_W-1:0] m);
    logic [DATA_W:0] m_ext;
    logic [DATA_W:0] sum;
    m_ext = {m[DATA_W-1], m};
    case ({q_in[0], q_m1})
      2'b01:   sum = a_in + m_ext;
      2'b10:   sum = a_in - m_ext;
      default: sum = a_in;
    endcase
    return {sum[DATA_W], sum, q_in};
  endfunction

  // One restoring-division step on magnitudes. Result layout: {R, Q}.
  function automatic logic [2*DATA_W:0] div_step(input logic [DATA_W:0]   r_in,
                                                 input logic [DATA_W-1:0] q_in,
                                                 input logic [DATA_W-1:0] d);
    logic [DATA_W:0] shifted;
    logic [DATA_W:0] trial;
    shifted = {r_in[DATA_W-1:0], q_in[DATA_W-1]};
    trial   = shifted - {1'b0, d};
    if (!trial[DATA_W])
      return {trial, q_in[DATA_W-2:0], 1'b1};
    else
      return {shifted, q_in[DATA_W-2:0], 1'b0};
  endfunction

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and datapath control strobes.
  always_comb begin
    state_nxt = state;
    cap       = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    dz        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (op && (b == '0)) begin
            dz        = 1'b1;
            state_nxt = FINISH;
          end else begin
            cap       = 1'b1;
            state_nxt = op ? DIV : MULT;
          end
        end
      end
      MULT, DIV: begin
        step = 1'b1;
        if (cnt == LAST_STEP) begin
          last      = 1'b1;
          state_nxt = FINISH;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Step results and the final, sign-corrected result of the running operation.
  always_comb begin
    booth_nxt = booth_step(acc, qreg, qm1, mreg);
    div_nxt   = div_step(acc, qreg, mreg);
    if (state == MULT) begin
      res_hi = booth_nxt[2*DATA_W:DATA_W+1];
      res_lo = booth_nxt[DATA_W:1];
    end else begin
      res_hi = neg_if(neg_r, div_nxt[2*DATA_W-1:DATA_W]);
      res_lo = neg_if(neg_q, div_nxt[DATA_W-1:0]);
    end
  end

  // Operand capture, iteration, result write-back and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= '0;
      acc      <= '0;
      qreg     <= '0;
      mreg     <= '0;
      qm1      <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      if (cap) begin
        cnt   <= '0;
        acc   <= '0;
        qm1   <= 1'b0;
        qreg  <= op ? abs_mag(a) : a;
        mreg  <= op ? abs_mag(b) : b;
        neg_q <= a[DATA_W-1] ^ b[DATA_W-1];
        neg_r <= a[DATA_W-1];
      end
      if (step) begin
        cnt <= cnt + 6'd1;
        if (state == MULT) begin
          acc  <= booth_nxt[2*DATA_W+1:DATA_W+1];
          qreg <= booth_nxt[DATA_W:1];
          qm1  <= booth_nxt[0];
        end else begin
          acc  <= div_nxt[2*DATA_W:DATA_W];
          qreg <= div_nxt[DATA_W-1:0];
        end
      end
      if (last) begin
        hi <= res_hi;
        lo <= res_lo;
      end
      busy     <= (state_nxt == MULT) || (state_nxt == DIV);
      done     <= last | dz;
      div_zero <= dz;
    end
  end

endmodule
